tsu_mc_stamp: RTL and testbench
===============================

// Module: tsu_mc_stamp
// PURPOSE
// Parametrised single-clock timestamp unit for a 1..8 byte-lane RX stream. Stamps frame start from RTC,
// with lane-position + static latency correction, holds stamp until the external PTP parser's verdict,
// queues PTP stamps in a sync FIFO with overflow/loss counters. Sits between MAC RX stream and CPU reader.
// PARAMETERS
// LANES    4   byte lanes per beat (1,2,4,8); lane 0 = earliest byte, rx_data[7:0]
// TS_W     36  stored stamp bits = {sec[TS_W-33:0], ns[31:0]}; 33..80
// INFO_W   20  parser info width (seqId16+msgId4 by default)
// DEPTH    16  FIFO entries, power of 2, 2..128
// LANE_NS  2   ns added per lane index of SOF lane
// CORR_NS  0   static ns correction; CORR_NS+(LANES-1)*LANE_NS < 1e9
// PORTS
// clk          in   1            single clock; all ports synchronous
// rst          in   1            synchronous active-high reset
// enable       in   1            0: no new stamps taken
// rx_ctrl      in   LANES        per-lane data valid
// rx_data      in   8*LANES      lane bytes (unused internally; reserved for debug tap)
// rtc_time_in  in   80           {sec48, ns32}, already in clk domain
// ptp_valid    in   1            parser verdict strobe, one per frame
// ptp_found    in   1            verdict: frame is PTP (qualified by ptp_valid)
// ptp_infor    in   INFO_W       parser info (qualified by ptp_valid)
// q_rd_en      in   1            pop head entry
// q_rd_data    out  INFO_W+8+TS_W  {infor, 8'h00, sec, ns}; 0 when empty
// q_rd_stat    out  8            entry count, zero-extended
// q_empty      out  1            FIFO empty
// q_full       out  1            FIFO full
// ovf_cnt      out  16           pushes dropped on full, saturating
// lost_cnt     out  16           stamps overwritten before verdict, saturating
// BEHAVIOUR
// - Reset: all outputs 0 (q_empty=1); FIFO, pending, pipeline, counters cleared; detector DISARMED.
// - Detector FSM: DISARMED -(beat with rx_ctrl==0)-> IDLE; IDLE -(|rx_ctrl)-> FRAME, SOF pulse;
//   FRAME -(~&rx_ctrl, i.e. any lane low)-> IDLE. Reset mid-frame never yields a spurious SOF.
// - SOF ignored (no stamp) when enable=0; FSM still tracks frames.
// - Stage1 (N+1): capture rtc_time_in of SOF beat N and k = index of lowest set rx_ctrl bit.
// - Stage2 (N+2): ns' = ns + k*LANE_NS + CORR_NS; if ns' >= 1_000_000_000: ns' -= 1e9, sec += 1
//   (sec wraps mod 2^48). Result loads pending stamp, pend_v=1.
// - Stage2 load while pend_v=1 and no verdict that cycle: overwrite, lost_cnt++.
// - Verdict (ptp_valid=1): uses pending value before any same-cycle stage2 load; clears pend_v
//   unless stage2 loads in that cycle (new stamp then becomes pending, no lost_cnt).
//   found=1 & pend_v: push; found=0: discard; pend_v=0: ignored, no push.
// - Push at verdict cycle V: entry visible (q_empty=0, q_rd_stat++) at V+1.
// - FIFO show-ahead: q_rd_data = head entry combinationally from storage; q_rd_en pops on edge.
//   rd_en when empty: ignored. Push when full w/o pop: dropped, ovf_cnt++.
//   Push+pop same cycle when full: both accepted, count unchanged. Both when empty: push only.
// - Counters saturate at 16'hFFFF; cleared only by rst.
// STRUCTURE
// - Package tsu_pkg: NS_PER_SEC=1_000_000_000, RTC_W=80, RTC sec/ns field offsets,
//   function lowest_lane(ctrl) -> index, Q_W helper function.
// - Sub-module tsu_sync_fifo (#DEPTH, #WIDTH): show-ahead, count/full/empty, overflow flag out.
// - Top: detector FSM, 2-stage stamp pipeline, pending register, verdict logic, counters.
// TESTING
// 1 LANES=4,LANE_NS=2: idle beat, rx_ctrl=4'b1100, rtc ns=1000 -> pending ns=1004 at N+2.
// 2 rtc {sec=5, ns=999_999_999}, lane 1, LANE_NS=8 -> stamp sec=6, ns=7.
// 3 verdict found=1, infor=20'hABCDE, sec=6, ns=7 -> q_rd_data={20'hABCDE,8'h00,4'h6,32'd7},
//   q_rd_stat=1; q_rd_en -> q_empty=1, q_rd_data=0.
// 4 DEPTH=16: 17 PTP frames no reads -> q_full=1, ovf_cnt=1; then push+pop same cycle -> count 16,
//   newest entry at tail.
// 5 two SOFs before verdict -> lost_cnt=1, pushed stamp = second; found=0 -> no push;
//   verdict with pend_v=0 -> no push.
// 6 rst while rx_ctrl=4'hF, held high 10 beats -> no stamp; idle beat then |rx_ctrl -> one stamp.

Source files
------------

// File: rtl/tsu_pkg.sv
// Shared constants, detector state type and small helpers for the timestamp unit.
package tsu_pkg;

    localparam int unsigned NS_PER_SEC  = 1_000_000_000;
    localparam int unsigned RTC_W       = 80;
    localparam int unsigned RTC_NS_LSB  = 0;
    localparam int unsigned RTC_NS_W    = 32;
    localparam int unsigned RTC_SEC_LSB = 32;
    localparam int unsigned RTC_SEC_W   = 48;

    typedef enum logic [1:0] {
        StDisarmed,
        StIdle,
        StFrame
    } det_state_e;

    // Index of the earliest valid lane; 0 when no lane is set.
    function automatic logic [2:0] lowest_lane(input logic [7:0] ctrl);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (ctrl[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Queue entry width: {infor, 8'h00, stamp}.
    function automatic int unsigned q_width(input int unsigned info_w, input int unsigned ts_w);
        return info_w + 8 + ts_w;
    endfunction

endpackage

// File: rtl/tsu_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a drop-on-full indication.
module tsu_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [7:0]       count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign do_pop   = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & ~do_push;
    assign rd_data  = empty ? '0 : mem[rd_ptr_q];

    // Zero-extend the occupancy to the fixed 8-bit status width.
    always_comb begin
        count = '0;
        count[AW:0] = cnt_q;
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_data;
    end

    // Pointer and occupancy update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + (AW + 1)'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - (AW + 1)'(1);
        end
    end

endmodule

// File: rtl/tsu_mc_stamp.sv
// Frame-start timestamp unit: SOF detector, two-stage stamp correction, pending stamp held
// until the parser verdict, and a queue of PTP stamps for the CPU reader.
module tsu_mc_stamp
    import tsu_pkg::*;
#(
    parameter int unsigned LANES   = 4,
    parameter int unsigned TS_W    = 36,
    parameter int unsigned INFO_W  = 20,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LANE_NS = 2,
    parameter int unsigned CORR_NS = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [LANES-1:0]                rx_ctrl,
    input  logic [8*LANES-1:0]              rx_data,
    input  logic [RTC_W-1:0]                rtc_time_in,
    input  logic                            ptp_valid,
    input  logic                            ptp_found,
    input  logic [INFO_W-1:0]               ptp_infor,
    input  logic                            q_rd_en,
    output logic [q_width(INFO_W, TS_W)-1:0] q_rd_data,
    output logic [7:0]                      q_rd_stat,
    output logic                            q_empty,
    output logic                            q_full,
    output logic [15:0]                     ovf_cnt,
    output logic [15:0]                     lost_cnt
);

    localparam int unsigned Q_W = q_width(INFO_W, TS_W);

    det_state_e       state_q, state_d;
    logic             sof;
    logic [7:0]       ctrl_ext;
    logic             s1_v_q;
    logic [RTC_W-1:0] s1_time_q;
    logic [2:0]       s1_lane_q;
    logic [33:0]      ns_sum;
    logic [33:0]      ns_adj;
    logic [47:0]      sec_adj;
    logic [TS_W-1:0]  stamp;
    logic             pend_v_q;
    logic [TS_W-1:0]  pend_ts_q;
    logic             s2_load;
    logic             push;
    logic             lost_inc;
    logic             fifo_ovf;
    logic [Q_W-1:0]   push_data;
    logic             unused_bits;

    // rx_data is only a debug tap; the top two ns bits are always zero after correction.
    assign unused_bits = ^{rx_data, ns_adj[33:32]};

    always_comb begin
        ctrl_ext = '0;
        ctrl_ext[LANES-1:0] = rx_ctrl;
    end

    // Detector state register; reset disarms so a frame in flight cannot produce an SOF.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StDisarmed;
        else     state_q <= state_d;
    end

    // Detector next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDisarmed: if (rx_ctrl == '0) state_d = StIdle;
            StIdle:     if (|rx_ctrl) state_d = StFrame;
            StFrame:    if (!(&rx_ctrl)) state_d = StIdle;
            default:    state_d = StDisarmed;
        endcase
    end

    // Detector output: SOF on the first active beat after an idle gap.
    always_comb begin
        sof = (state_q == StIdle) && (|rx_ctrl);
    end

    // Stage 1: capture RTC and SOF lane of the start beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q    <= 1'b0;
            s1_time_q <= '0;
            s1_lane_q <= '0;
        end else begin
            s1_v_q <= sof & enable;
            if (sof) begin
                s1_time_q <= rtc_time_in;
                s1_lane_q <= lowest_lane(ctrl_ext);
            end
        end
    end

    // Stage 2 arithmetic: lane and static correction with a single ns-to-sec carry.
    always_comb begin
        ns_sum  = 34'(s1_time_q[RTC_NS_LSB +: RTC_NS_W]) + 34'(s1_lane_q) * 34'(LANE_NS)
                + 34'(CORR_NS);
        ns_adj  = ns_sum;
        sec_adj = s1_time_q[RTC_SEC_LSB +: RTC_SEC_W];
        if (ns_sum >= 34'(NS_PER_SEC)) begin
            ns_adj  = ns_sum - 34'(NS_PER_SEC);
            sec_adj = sec_adj + 48'd1;
        end
        stamp = TS_W'({sec_adj, ns_adj[31:0]});
    end

    assign s2_load   = s1_v_q;
    // The verdict always judges the stamp held before any same-cycle load.
    assign push      = ptp_valid & ptp_found & pend_v_q;
    assign lost_inc  = s2_load & pend_v_q & ~ptp_valid;
    assign push_data = {ptp_infor, 8'h00, pend_ts_q};

    // Pending stamp: a stage 2 load wins over the verdict clearing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v_q  <= 1'b0;
            pend_ts_q <= '0;
        end else if (s2_load) begin
            pend_v_q  <= 1'b1;
            pend_ts_q <= stamp;
        end else if (ptp_valid) begin
            pend_v_q  <= 1'b0;
        end
    end

    // Saturating loss and overflow counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lost_cnt <= '0;
            ovf_cnt  <= '0;
        end else begin
            if (lost_inc && lost_cnt != 16'hFFFF) lost_cnt <= lost_cnt + 16'd1;
            if (fifo_ovf && ovf_cnt != 16'hFFFF)  ovf_cnt  <= ovf_cnt + 16'd1;
        end
    end

    tsu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (Q_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_data  (push_data),
        .pop      (q_rd_en),
        .rd_data  (q_rd_data),
        .count    (q_rd_stat),
        .full     (q_full),
        .empty    (q_empty),
        .overflow (fifo_ovf)
    );

endmodule

// File: tb/tb_tsu_mc_stamp.sv
// Directed bench: two instances share stimulus, one with LANE_NS=2 (a) and one with LANE_NS=8 (b).
module tb_tsu_mc_stamp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic [3:0]  rx_ctrl = '0;
    logic [31:0] rx_data = '0;
    logic [79:0] rtc = '0;
    logic        ptp_valid = 1'b0;
    logic        ptp_found = 1'b0;
    logic [19:0] ptp_infor = '0;
    logic        q_rd_en = 1'b0;

    logic [63:0] rd_data_a, rd_data_b;
    logic [7:0]  stat_a, stat_b;
    logic        empty_a, empty_b, full_a, full_b;
    logic [15:0] ovf_a, ovf_b, lost_a, lost_b;

    int checks = 0;
    int fails = 0;

    tsu_mc_stamp #(.LANES(4), .TS_W(36), .INFO_W(20), .DEPTH(16), .LANE_NS(2), .CORR_NS(0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rx_ctrl(rx_ctrl), .rx_data(rx_data),
        .rtc_time_in(rtc), .ptp_valid(ptp_valid), .ptp_found(ptp_found), .ptp_infor(ptp_infor),
        .q_rd_en(q_rd_en), .q_rd_data(rd_data_a), .q_rd_stat(stat_a), .q_empty(empty_a),
        .q_full(full_a), .ovf_cnt(ovf_a), .lost_cnt(lost_a)
    );

    tsu_mc_stamp #(.LANES(4), .TS_W(36), .INFO_W(20), .DEPTH(16), .LANE_NS(8), .CORR_NS(0)) dut8 (
        .clk(clk), .rst(rst), .enable(enable), .rx_ctrl(rx_ctrl), .rx_data(rx_data),
        .rtc_time_in(rtc), .ptp_valid(ptp_valid), .ptp_found(ptp_found), .ptp_infor(ptp_infor),
        .q_rd_en(q_rd_en), .q_rd_data(rd_data_b), .q_rd_stat(stat_b), .q_empty(empty_b),
        .q_full(full_b), .ovf_cnt(ovf_b), .lost_cnt(lost_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] entry(input logic [19:0] infor, input logic [3:0] sec,
                                          input logic [31:0] ns);
        return {infor, 8'h00, sec, ns};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_ctrl = '0; ptp_valid = 1'b0; q_rd_en = 1'b0; enable = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // SOF beat N, idle beat N+1, verdict in N+2; returns in N+3.
    task automatic run_frame(input logic [3:0] ctrl, input logic [47:0] sec, input logic [31:0] ns,
                             input logic found, input logic [19:0] infor, input logic rd);
        rtc = {sec, ns}; rx_ctrl = ctrl; tick();
        rx_ctrl = '0; tick();
        ptp_valid = 1'b1; ptp_found = found; ptp_infor = infor; q_rd_en = rd; tick();
        ptp_valid = 1'b0; ptp_found = 1'b0; q_rd_en = 1'b0;
    endtask

    task automatic pop();
        q_rd_en = 1'b1; tick(); q_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_ctrl = '0; ptp_valid = 1'b0; q_rd_en = 1'b0;
        tick(); tick();
        checks++; if (empty_a !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b required 1", empty_a); end
        checks++; if (full_a !== 1'b0) begin fails++; $display("FAIL reset_full: got %b required 0", full_a); end
        checks++; if (stat_a !== 8'd0) begin fails++; $display("FAIL reset_stat: got %0d required 0", stat_a); end
        checks++; if (rd_data_a !== 64'd0) begin fails++; $display("FAIL reset_data: got %h required 0", rd_data_a); end
        checks++; if (ovf_a !== 16'd0) begin fails++; $display("FAIL reset_ovf: got %0d required 0", ovf_a); end
        checks++; if (lost_a !== 16'd0) begin fails++; $display("FAIL reset_lost: got %0d required 0", lost_a); end
        rst = 1'b0;
    endtask

    task automatic test_lane_offset();
        do_reset();
        rtc = {48'd3, 32'd1000}; rx_ctrl = 4'b1100; tick();
        // Verdict at N+1 comes before the stamp is pending and must be ignored.
        rx_ctrl = '0; ptp_valid = 1'b1; ptp_found = 1'b1; ptp_infor = 20'h11111; tick();
        checks++; if (stat_a !== 8'd0) begin fails++; $display("FAIL early_verdict: got stat %0d required 0", stat_a); end
        ptp_infor = 20'h12345; tick();
        ptp_valid = 1'b0; ptp_found = 1'b0;
        checks++; if (stat_a !== 8'd1) begin fails++; $display("FAIL lane_stat: got %0d required 1", stat_a); end
        checks++; if (rd_data_a !== entry(20'h12345, 4'h3, 32'd1004)) begin
            fails++; $display("FAIL lane_ns2: got %h required %h", rd_data_a, entry(20'h12345, 4'h3, 32'd1004)); end
        checks++; if (rd_data_b !== entry(20'h12345, 4'h3, 32'd1016)) begin
            fails++; $display("FAIL lane_ns8: got %h required %h", rd_data_b, entry(20'h12345, 4'h3, 32'd1016)); end
        pop();
        checks++; if (empty_a !== 1'b1) begin fails++; $display("FAIL lane_pop_empty: got %b required 1", empty_a); end
    endtask

    task automatic test_rollover();
        do_reset();
        run_frame(4'b1110, 48'd5, 32'd999_999_999, 1'b1, 20'hABCDE, 1'b0);
        checks++; if (rd_data_b !== entry(20'hABCDE, 4'h6, 32'd7)) begin
            fails++; $display("FAIL roll_ns8: got %h required %h", rd_data_b, entry(20'hABCDE, 4'h6, 32'd7)); end
        checks++; if (rd_data_a !== entry(20'hABCDE, 4'h6, 32'd1)) begin
            fails++; $display("FAIL roll_ns2: got %h required %h", rd_data_a, entry(20'hABCDE, 4'h6, 32'd1)); end
        checks++; if (stat_b !== 8'd1 || empty_b !== 1'b0) begin
            fails++; $display("FAIL roll_stat: got stat %0d empty %b required 1 0", stat_b, empty_b); end
        pop();
        checks++; if (empty_b !== 1'b1 || rd_data_b !== 64'd0 || stat_b !== 8'd0) begin
            fails++; $display("FAIL roll_pop: got empty %b data %h stat %0d required 1 0 0", empty_b, rd_data_b, stat_b); end
        // Pop on empty is ignored.
        pop();
        checks++; if (stat_b !== 8'd0 || empty_b !== 1'b1) begin
            fails++; $display("FAIL empty_pop: got stat %0d empty %b required 0 1", stat_b, empty_b); end
        // Seconds wrap modulo 2^48.
        run_frame(4'b1110, 48'hFFFF_FFFF_FFFF, 32'd999_999_995, 1'b1, 20'h00001, 1'b0);
        checks++; if (rd_data_b !== entry(20'h00001, 4'h0, 32'd3)) begin
            fails++; $display("FAIL sec_wrap: got %h required %h", rd_data_b, entry(20'h00001, 4'h0, 32'd3)); end
    endtask

    task automatic test_enable();
        do_reset();
        enable = 1'b0;
        run_frame(4'b0001, 48'd0, 32'd50, 1'b1, 20'h0E0E0, 1'b0);
        enable = 1'b1;
        checks++; if (stat_a !== 8'd0) begin fails++; $display("FAIL disabled_stamp: got stat %0d required 0", stat_a); end
        run_frame(4'b0001, 48'd0, 32'd60, 1'b1, 20'h0E0E1, 1'b0);
        checks++; if (rd_data_a !== entry(20'h0E0E1, 4'h0, 32'd60) || stat_a !== 8'd1) begin
            fails++; $display("FAIL reenabled: got %h stat %0d required %h 1", rd_data_a, stat_a, entry(20'h0E0E1, 4'h0, 32'd60)); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < 17; i++) run_frame(4'b0001, 48'd0, 32'(i), 1'b1, 20'(i), 1'b0);
        checks++; if (full_a !== 1'b1 || stat_a !== 8'd16) begin
            fails++; $display("FAIL fill: got full %b stat %0d required 1 16", full_a, stat_a); end
        checks++; if (ovf_a !== 16'd1) begin fails++; $display("FAIL ovf: got %0d required 1", ovf_a); end
        checks++; if (rd_data_a !== entry(20'd0, 4'h0, 32'd0)) begin
            fails++; $display("FAIL full_head: got %h required %h", rd_data_a, entry(20'd0, 4'h0, 32'd0)); end
        run_frame(4'b0001, 48'd2, 32'd777, 1'b1, 20'hF0F0F, 1'b1);
        checks++; if (stat_a !== 8'd16 || full_a !== 1'b1 || ovf_a !== 16'd1) begin
            fails++; $display("FAIL push_pop_full: got stat %0d full %b ovf %0d required 16 1 1", stat_a, full_a, ovf_a); end
        for (int j = 1; j < 16; j++) begin
            checks++; if (rd_data_a !== entry(20'(j), 4'h0, 32'(j))) begin
                fails++; $display("FAIL drain_%0d: got %h required %h", j, rd_data_a, entry(20'(j), 4'h0, 32'(j))); end
            pop();
        end
        checks++; if (rd_data_a !== entry(20'hF0F0F, 4'h2, 32'd777)) begin
            fails++; $display("FAIL tail_newest: got %h required %h", rd_data_a, entry(20'hF0F0F, 4'h2, 32'd777)); end
        pop();
        checks++; if (empty_a !== 1'b1) begin fails++; $display("FAIL drained_empty: got %b required 1", empty_a); end
    endtask

    task automatic test_lost();
        do_reset();
        rtc = {48'd1, 32'd10}; rx_ctrl = 4'b0001; tick();
        rx_ctrl = '0; tick();
        rtc = {48'd1, 32'd20}; rx_ctrl = 4'b0001; tick();
        rx_ctrl = '0; tick();
        ptp_valid = 1'b1; ptp_found = 1'b1; ptp_infor = 20'h00005; tick();
        ptp_valid = 1'b0; ptp_found = 1'b0;
        checks++; if (lost_a !== 16'd1) begin fails++; $display("FAIL lost_cnt: got %0d required 1", lost_a); end
        checks++; if (stat_a !== 8'd1 || rd_data_a !== entry(20'h00005, 4'h1, 32'd20)) begin
            fails++; $display("FAIL lost_second: got %h stat %0d required %h 1", rd_data_a, stat_a, entry(20'h00005, 4'h1, 32'd20)); end
        run_frame(4'b0001, 48'd0, 32'd30, 1'b0, 20'h00006, 1'b0);
        checks++; if (stat_a !== 8'd1 || lost_a !== 16'd1) begin
            fails++; $display("FAIL not_ptp: got stat %0d lost %0d required 1 1", stat_a, lost_a); end
        ptp_valid = 1'b1; ptp_found = 1'b1; ptp_infor = 20'h00007; tick();
        ptp_valid = 1'b0; ptp_found = 1'b0;
        checks++; if (stat_a !== 8'd1 || rd_data_a !== entry(20'h00005, 4'h1, 32'd20)) begin
            fails++; $display("FAIL no_pending: got %h stat %0d required %h 1", rd_data_a, stat_a, entry(20'h00005, 4'h1, 32'd20)); end
    endtask

    task automatic test_reset_midframe();
        rx_ctrl = 4'hF; rst = 1'b1; tick(); tick();
        rst = 1'b0;
        repeat (10) tick();
        rx_ctrl = '0; tick(); tick();
        ptp_valid = 1'b1; ptp_found = 1'b1; ptp_infor = 20'h00008; tick();
        ptp_valid = 1'b0; ptp_found = 1'b0;
        checks++; if (stat_a !== 8'd0 || stat_b !== 8'd0) begin
            fails++; $display("FAIL spurious_sof: got stat %0d/%0d required 0", stat_a, stat_b); end
        run_frame(4'hF, 48'd0, 32'd40, 1'b1, 20'h00009, 1'b0);
        checks++; if (stat_a !== 8'd1 || rd_data_a !== entry(20'h00009, 4'h0, 32'd40)) begin
            fails++; $display("FAIL armed_sof: got %h stat %0d required %h 1", rd_data_a, stat_a, entry(20'h00009, 4'h0, 32'd40)); end
    endtask

    initial begin
        test_reset();
        test_lane_offset();
        test_rollover();
        test_enable();
        test_fifo_full();
        test_lost();
        test_reset();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
